handball_game_param: RTL and testbench



---
 rtl/handball_game_param.sv | 145 ++++++++++++++
 tb/tb_handball_game_param.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/handball_game_param.sv
// Single-player LED-bar handball: a one-hot ball runs to the wall at bit 0 and back.
// The player must strike it inside the top HIT_WIN positions; score, misses and early swings are tracked.
module handball_game_param #(
  parameter int WIDTH    = 8,
  parameter int TICK_DIV = 4,
  parameter int MIN_DIV  = 1,
  parameter int HIT_WIN  = 1,
  parameter int SCORE_W  = 4,
  parameter int SPEEDUP  = 0
) (
  input  logic               CLKK,
  input  logic               RESET,
  input  logic               START,
  input  logic               PULSER,
  output logic [WIDTH-1:0]   LGOUT,
  output logic [SCORE_W-1:0] SCORE,
  output logic               GAME_OVER,
  output logic               BALL_DIR
);

  localparam int PW = $clog2(TICK_DIV + 1);
  localparam logic [PW-1:0]      TD_P      = PW'(TICK_DIV);
  localparam logic [PW-1:0]      MD_P      = PW'(MIN_DIV);
  localparam logic [WIDTH-1:0]   WIN_MASK  = {WIDTH{1'b1}} << (WIDTH - HIT_WIN);
  localparam logic [WIDTH-1:0]   BALL_TOP  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0]   BALL_BIT1 = {{(WIDTH-2){1'b0}}, 2'b10};
  localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_OUT  = 2'd1,
    S_BACK = 2'd2,
    S_OVER = 2'd3
  } state_t;

  state_t             state_q;
  logic [WIDTH-1:0]   lgout_q;
  logic [SCORE_W-1:0] score_q;
  logic               game_over_q;
  logic               ball_dir_q;
  logic [PW-1:0]      period_q;
  logic [PW-1:0]      tick_cnt_q;
  logic               pulser_prev_q;

  logic press_s;
  logic step_s;
  logic in_win_s;

  always_comb begin
    press_s  = PULSER & ~pulser_prev_q;
    step_s   = (tick_cnt_q == (period_q - PW'(1)));
    in_win_s = |(lgout_q & WIN_MASK);
  end

  // Priority: RESET > START > press (hit/fault) > ball step
  always_ff @(posedge CLKK) begin
    pulser_prev_q <= RESET ? 1'b1 : PULSER;
    if (RESET) begin
      state_q     <= S_IDLE;
      lgout_q     <= '0;
      score_q     <= '0;
      game_over_q <= 1'b0;
      ball_dir_q  <= 1'b0;
      period_q    <= TD_P;
      tick_cnt_q  <= '0;
    end else if (START) begin
      state_q     <= S_OUT;
      lgout_q     <= BALL_TOP;
      score_q     <= '0;
      game_over_q <= 1'b0;
      ball_dir_q  <= 1'b0;
      period_q    <= TD_P;
      tick_cnt_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          lgout_q <= '0;
        end
        S_OUT: begin
          if (press_s) begin
            state_q     <= S_OVER;
            lgout_q     <= '1;
            game_over_q <= 1'b1;
          end else if (step_s) begin
            tick_cnt_q <= '0;
            if (lgout_q[0]) begin
              lgout_q    <= BALL_BIT1;
              ball_dir_q <= 1'b1;
              state_q    <= S_BACK;
            end else begin
              lgout_q <= lgout_q >> 1;
            end
          end else begin
            tick_cnt_q <= tick_cnt_q + PW'(1);
          end
        end
        S_BACK: begin
          if (press_s) begin
            if (in_win_s) begin
              // The ball holds its position; only the direction flips.
              state_q    <= S_OUT;
              ball_dir_q <= 1'b0;
              tick_cnt_q <= '0;
              if (score_q != SCORE_MAX) begin
                score_q <= score_q + SCORE_W'(1);
              end
              if ((SPEEDUP != 0) && (period_q > MD_P)) begin
                period_q <= period_q - PW'(1);
              end
            end else begin
              state_q     <= S_OVER;
              lgout_q     <= '1;
              game_over_q <= 1'b1;
            end
          end else if (step_s) begin
            tick_cnt_q <= '0;
            if (lgout_q[WIDTH-1]) begin
              state_q     <= S_OVER;
              lgout_q     <= '1;
              game_over_q <= 1'b1;
            end else begin
              lgout_q <= {lgout_q[WIDTH-2:0], 1'b0};
            end
          end else begin
            tick_cnt_q <= tick_cnt_q + PW'(1);
          end
        end
        S_OVER: begin
          lgout_q     <= '1;
          game_over_q <= 1'b1;
        end
        default: begin
          state_q <= S_IDLE;
          lgout_q <= '0;
        end
      endcase
    end
  end

  assign LGOUT     = lgout_q;
  assign SCORE     = score_q;
  assign GAME_OVER = game_over_q;
  assign BALL_DIR  = ball_dir_q;

endmodule

// File: tb/tb_handball_game_param.sv
// Randomised scoreboard bench: two game instances (fixed speed and speed-up) share
// the stimulus; a position-based reference model predicts every cycle's outputs.
module tb_handball_game_param;

  localparam int W  = 8;
  localparam int HW = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic pulser = 1'b0;

  logic [7:0] lg0, lg1;
  logic [3:0] sc0, sc1;
  logic       go0, go1, dir0, dir1;

  always #5 clk = ~clk;

  handball_game_param #(.WIDTH(8), .TICK_DIV(2), .MIN_DIV(1), .HIT_WIN(2),
                        .SCORE_W(4), .SPEEDUP(0)) dut0 (
    .CLKK(clk), .RESET(rst), .START(start), .PULSER(pulser),
    .LGOUT(lg0), .SCORE(sc0), .GAME_OVER(go0), .BALL_DIR(dir0));

  handball_game_param #(.WIDTH(8), .TICK_DIV(4), .MIN_DIV(2), .HIT_WIN(2),
                        .SCORE_W(4), .SPEEDUP(1)) dut1 (
    .CLKK(clk), .RESET(rst), .START(start), .PULSER(pulser),
    .LGOUT(lg1), .SCORE(sc1), .GAME_OVER(go1), .BALL_DIR(dir1));

  typedef struct packed {
    logic [7:0] lg;
    logic [3:0] sc;
    logic       go;
    logic       dir;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  int checks = 0;
  int errors = 0;

  // Reference model: phase 0 idle, 1 outbound, 2 returning, 3 over; pos = lit bit index.
  int td[2] = '{2, 4};
  int md[2] = '{1, 2};
  int su[2] = '{0, 1};
  int phase[2], pos[2], score[2], period[2], tick[2], dirv[2];
  bit prev_p;
  int max_score_seen[2];
  int min_period_seen[2];

  task automatic model_step(input int k, input bit r, input bit s, input bit press);
    if (r) begin
      phase[k] = 0; score[k] = 0; dirv[k] = 0; period[k] = td[k]; tick[k] = 0;
    end else if (s) begin
      phase[k] = 1; pos[k] = W - 1; score[k] = 0; dirv[k] = 0; period[k] = td[k]; tick[k] = 0;
    end else if (phase[k] == 1) begin
      if (press) phase[k] = 3;
      else if (tick[k] == period[k] - 1) begin
        tick[k] = 0;
        if (pos[k] == 0) begin pos[k] = 1; dirv[k] = 1; phase[k] = 2; end
        else pos[k] = pos[k] - 1;
      end else tick[k] = tick[k] + 1;
    end else if (phase[k] == 2) begin
      if (press) begin
        if (pos[k] >= W - HW) begin
          phase[k] = 1; dirv[k] = 0; tick[k] = 0;
          if (score[k] < 15) score[k] = score[k] + 1;
          if (su[k] != 0 && period[k] > md[k]) period[k] = period[k] - 1;
        end else phase[k] = 3;
      end else if (tick[k] == period[k] - 1) begin
        tick[k] = 0;
        if (pos[k] == W - 1) phase[k] = 3;
        else pos[k] = pos[k] + 1;
      end else tick[k] = tick[k] + 1;
    end
    if (score[k] > max_score_seen[k]) max_score_seen[k] = score[k];
    if (phase[k] != 0 && period[k] < min_period_seen[k]) min_period_seen[k] = period[k];
  endtask

  function automatic exp_t expect_of(input int k);
    exp_t e;
    e.lg  = (phase[k] == 3) ? 8'hFF : (phase[k] == 0) ? 8'h00 : 8'(1 << pos[k]);
    e.sc  = 4'(score[k]);
    e.go  = (phase[k] == 3);
    e.dir = dirv[k][0];
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Monitor: one expectation per clock edge for each instance.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q0.size() > 0) begin
        e = q0.pop_front();
        check("lgout0", 32'(lg0), 32'(e.lg));
        check("score0", 32'(sc0), 32'(e.sc));
        check("over0", 32'(go0), 32'(e.go));
        check("dir0", 32'(dir0), 32'(e.dir));
      end
      if (q1.size() > 0) begin
        e = q1.pop_front();
        check("lgout1", 32'(lg1), 32'(e.lg));
        check("score1", 32'(sc1), 32'(e.sc));
        check("over1", 32'(go1), 32'(e.go));
        check("dir1", 32'(dir1), 32'(e.dir));
      end
    end
  end

  // mode: 0 reset, 1 random play, 2/3 skilled player tracking instance 0/1
  task automatic drive_cycle(input int mode);
    bit r, s, p, press;
    int k;
    @(negedge clk);
    r = 1'b0; s = 1'b0; p = 1'b0;
    if (mode == 0) begin
      r = 1'b1;
      p = ($urandom_range(0, 1) == 0);
    end else if (mode == 1) begin
      r = ($urandom_range(0, 699) == 0);
      if (phase[0] == 0 || phase[0] == 3) s = ($urandom_range(0, 39) == 0);
      else s = ($urandom_range(0, 199) == 0);
      p = ($urandom_range(0, 3) == 0) ? ~pulser : pulser;
    end else begin
      k = mode - 2;
      r = ($urandom_range(0, 1999) == 0);
      if (phase[k] == 0 || phase[k] == 3) s = ($urandom_range(0, 3) == 0);
      else s = ($urandom_range(0, 499) == 0);
      if (!pulser && phase[k] == 2 && pos[k] >= W - HW) begin
        p = ($urandom_range(0, 1) == 0) || (pos[k] == W - 1 && tick[k] == period[k] - 1);
      end else begin
        p = ($urandom_range(0, 499) == 0);
      end
    end
    rst = r; start = s; pulser = p;
    press = p & ~prev_p;
    prev_p = r ? 1'b1 : p;
    for (int i = 0; i < 2; i++) begin
      model_step(i, r, s, press);
    end
    q0.push_back(expect_of(0));
    q1.push_back(expect_of(1));
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      phase[i] = 0; pos[i] = 0; score[i] = 0; period[i] = td[i]; tick[i] = 0; dirv[i] = 0;
      max_score_seen[i] = 0; min_period_seen[i] = td[i];
    end
    prev_p = 1'b1;
    repeat (2) drive_cycle(0);
    repeat (1500) drive_cycle(1);
    repeat (3) drive_cycle(0);
    repeat (3000) drive_cycle(2);
    repeat (3000) drive_cycle(3);
    repeat (1500) drive_cycle(1);
    @(negedge clk);
    rst = 1'b0; start = 1'b0; pulser = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    check("queue_drained", 32'(q0.size() + q1.size()), 32'd0);
    if (max_score_seen[0] < 15)
      $display("note: score saturation not reached on instance 0 (max %0d)", max_score_seen[0]);
    if (min_period_seen[1] > 2)
      $display("note: speed-up floor not reached on instance 1 (min %0d)", min_period_seen[1]);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
